// File: rtl/press_rng_source_if.sv
// rtl/press_rng_source_if.sv - control/value bundle between press_rng_source and the threshold comparator
// lock_err exists only when PRESS_RNG_LOCKUP_RECOVER_EN is defined.
interface press_rng_source_if #(
  parameter int WIDTH = 10
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] rnd;
  logic             tick;
`ifdef PRESS_RNG_LOCKUP_RECOVER_EN
  logic             lock_err;

  modport master (output en, load, seed, input rnd, tick, lock_err);
  modport slave  (input en, load, seed, output rnd, tick, lock_err);
`else
  modport master (output en, load, seed, input rnd, tick);
  modport slave  (input en, load, seed, output rnd, tick);
`endif
endinterface

// File: rtl/press_rng_source.sv
// rtl/press_rng_source.sv - paced 10-bit XNOR LFSR supplying the comparator "a" operand
// Optional PRESS_RNG_LOCKUP_RECOVER_EN: remaps a 3FF seed to 000 and raises sticky lock_err.
module press_rng_source #(
  parameter int WIDTH  = 10,
  parameter int PERIOD = 4,
  parameter int CNT_W  = 10
) (
  input  logic               clk,
  input  logic               reset,
  press_rng_source_if.slave  bus
);

  if (WIDTH != 10) begin : g_bad_width
    $error("press_rng_source: taps are defined for WIDTH=10 only");
  end
  if (PERIOD < 1 || PERIOD > 1023) begin : g_bad_period
    $error("press_rng_source: PERIOD must be in 1..1023");
  end
  if ((1 << CNT_W) < PERIOD) begin : g_bad_cnt_w
    $error("press_rng_source: CNT_W too narrow for PERIOD");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rnd_q, rnd_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] lfsr_next;

  // x^10 + x^7 + 1 in XNOR form: all-ones is the lockup point
  assign lfsr_next = {rnd_q[WIDTH-2:0], ~(rnd_q[9] ^ rnd_q[6])};

`ifdef PRESS_RNG_LOCKUP_RECOVER_EN
  logic lock_q, lock_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rnd_d   = rnd_q;
    tick_d  = 1'b0;
`ifdef PRESS_RNG_LOCKUP_RECOVER_EN
    lock_d  = lock_q;
`endif
    if (bus.load) begin
      // load wins over a step due this cycle; the FSM state is left alone
      cnt_d = '0;
`ifdef PRESS_RNG_LOCKUP_RECOVER_EN
      if (bus.seed == {WIDTH{1'b1}}) begin
        rnd_d  = '0;
        lock_d = 1'b1;
      end else begin
        rnd_d = bus.seed;
      end
`else
      rnd_d = bus.seed;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (bus.en) state_d = RUN;
        end
        RUN, HOLD: begin
          // an enabled HOLD cycle resumes counting immediately from the held count
          if (bus.en) begin
            state_d = RUN;
            if (cnt_q == LAST) begin
              cnt_d  = '0;
              rnd_d  = lfsr_next;
              tick_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rnd_q   <= '0;
      tick_q  <= 1'b0;
`ifdef PRESS_RNG_LOCKUP_RECOVER_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
      tick_q  <= tick_d;
`ifdef PRESS_RNG_LOCKUP_RECOVER_EN
      lock_q  <= lock_d;
`endif
    end
  end

  assign bus.rnd  = rnd_q;
  assign bus.tick = tick_q;
`ifdef PRESS_RNG_LOCKUP_RECOVER_EN
  assign bus.lock_err = lock_q;
`endif

endmodule

// File: tb/tb_press_rng_source.sv
// tb/tb_press_rng_source.sv - scoreboard bench for press_rng_source (PERIOD=4 main unit, PERIOD=1 side unit)
module tb_press_rng_source;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  press_rng_source_if #(.WIDTH(10)) bus ();
  press_rng_source_if #(.WIDTH(10)) bus1 ();

  press_rng_source #(.WIDTH(10), .PERIOD(4), .CNT_W(10)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  press_rng_source #(.WIDTH(10), .PERIOD(1), .CNT_W(10)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  typedef struct {
    int         e;
    logic [9:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   edge_n = 0;
  logic in_free = 1'b0;
  logic saw_3ff = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int e, input logic [9:0] v);
    exp_t x;
    x.e = e;
    x.v = v;
    exp_q.push_back(x);
  endtask

  function automatic logic [9:0] lfsr(input logic [9:0] v);
    return {v[8:0], ~(v[9] ^ v[6])};
  endfunction

  // monitor: every tick must match the next expected (edge, value) pair
  always @(negedge clk) begin
    if (in_free && bus.rnd == 10'h3FF) saw_3ff = 1'b1;
    if (bus.tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_tick: got tick rnd=%0h at edge %0d, expected no tick", bus.rnd, edge_n);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("tick_edge", edge_n, x.e);
        check("tick_rnd", {22'd0, bus.rnd}, {22'd0, x.v});
      end
    end
  end

  initial begin
    int e;
    logic [9:0] m;
    logic [9:0] seq1[4]  = '{10'h001, 10'h003, 10'h007, 10'h00F};
    logic [9:0] p1[8]    = '{10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F, 10'h03F, 10'h07F, 10'h0FE};
`ifdef PRESS_RNG_LOCKUP_RECOVER_EN
    logic [9:0] lockv[10] = '{10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F,
                              10'h03F, 10'h07F, 10'h0FE, 10'h1FC, 10'h3F8};
`endif

    bus.en = 1'b0;  bus.load = 1'b0;  bus.seed = '0;
    bus1.en = 1'b0; bus1.load = 1'b0; bus1.seed = '0;
    reset = 1'b1;
    step_clk(2);
    check("reset_rnd", {22'd0, bus.rnd}, 32'h000);
    check("reset_tick", {31'd0, bus.tick}, 32'd0);
`ifdef PRESS_RNG_LOCKUP_RECOVER_EN
    check("reset_lock_err", {31'd0, bus.lock_err}, 32'd0);
`endif

    // run from reset: IDLE->RUN on e+1, first step PERIOD edges later
    reset = 1'b0;
    bus.en = 1'b1;
    bus1.en = 1'b1;
    e = edge_n;
    for (int i = 0; i < 4; i++) push(e + 5 + 4 * i, seq1[i]);

    // PERIOD=1 unit: steps every RUN cycle, tick held high
    step_clk(2);
    for (int i = 0; i < 8; i++) begin
      check("p1_tick_high", {31'd0, bus1.tick}, 32'd1);
      check("p1_rnd", {22'd0, bus1.rnd}, {22'd0, p1[i]});
      step_clk(1);
    end
    step_clk(7);

    // seed load then two steps
    bus.load = 1'b1;
    bus.seed = 10'h07F;
    step_clk(1);
    e = edge_n;
    bus.load = 1'b0;
    check("load_07f_rnd", {22'd0, bus.rnd}, 32'h07F);
    check("load_07f_tick", {31'd0, bus.tick}, 32'd0);
    push(e + 4, 10'h0FE);
    push(e + 8, 10'h1FC);
    step_clk(10);

    // freeze with counter at 2 for three cycles
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_clk(1);
      check("hold_tick", {31'd0, bus.tick}, 32'd0);
      check("hold_rnd", {22'd0, bus.rnd}, 32'h1FC);
    end
    bus.en = 1'b1;
    e = edge_n;
    push(e + 2, 10'h3F8);
    step_clk(2);

    // load on the cycle a step is due: step dropped, counter restarts
    step_clk(3);
    bus.load = 1'b1;
    bus.seed = 10'h155;
    step_clk(1);
    e = edge_n;
    bus.load = 1'b0;
    check("load_due_rnd", {22'd0, bus.rnd}, 32'h155);
    check("load_due_tick", {31'd0, bus.tick}, 32'd0);
    push(e + 4, 10'h2AA);
    step_clk(4);

    // full period from seed 001
    bus.load = 1'b1;
    bus.seed = 10'h001;
    step_clk(1);
    e = edge_n;
    bus.load = 1'b0;
    in_free = 1'b1;
    m = 10'h001;
    for (int k = 1; k <= 1023; k++) begin
      m = lfsr(m);
      push(e + 4 * k, m);
    end
    step_clk(4 * 1023);
    check("free_wrap_rnd", {22'd0, bus.rnd}, 32'h001);
    step_clk(1);
    in_free = 1'b0;
    check("free_no_3ff", {31'd0, saw_3ff}, 32'd0);

    // lockup seed
    bus.load = 1'b1;
    bus.seed = 10'h3FF;
    step_clk(1);
    e = edge_n;
    bus.load = 1'b0;
`ifdef PRESS_RNG_LOCKUP_RECOVER_EN
    check("lock_load_rnd", {22'd0, bus.rnd}, 32'h000);
    check("lock_err_set", {31'd0, bus.lock_err}, 32'd1);
    for (int k = 1; k <= 10; k++) push(e + 4 * k, lockv[k-1]);
    step_clk(40);
    check("lock_err_sticky", {31'd0, bus.lock_err}, 32'd1);
    check("lock_final_rnd", {22'd0, bus.rnd}, 32'h3F8);
`else
    check("lockup_load_rnd", {22'd0, bus.rnd}, 32'h3FF);
    for (int k = 1; k <= 10; k++) push(e + 4 * k, 10'h3FF);
    step_clk(40);
    check("lockup_final_rnd", {22'd0, bus.rnd}, 32'h3FF);
`endif

    // reset on the edge a step is due
    step_clk(3);
    reset = 1'b1;
    bus.en = 1'b0;
    bus1.en = 1'b0;
    step_clk(1);
    check("midrun_reset_rnd", {22'd0, bus.rnd}, 32'h000);
    check("midrun_reset_tick", {31'd0, bus.tick}, 32'd0);
`ifdef PRESS_RNG_LOCKUP_RECOVER_EN
    check("midrun_reset_lock", {31'd0, bus.lock_err}, 32'd0);
`endif
    step_clk(1);
    reset = 1'b0;
    step_clk(12);
    check("all_ticks_seen", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
